// File: rtl/fp_to_linear_seq.sv
// fp_to_linear_seq
//   Decodes the 8-bit float {S, E[EXP_W-1:0], F[MANT_W-1:0]} into a signed linear
//   value D = (-1)^S * F * 2^E. The left shift is done one bit per clock, so the
//   result appears E+2 cycles after the accept edge.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   S, E, F             sign, exponent (shift count) and unsigned mantissa
//   out_valid/out_ready output handshake; D is held while out_valid waits
//   D                   signed DATA_W-bit result (keeps its last value after hand-off)
//   busy                high in every state except IDLE
// MANT_W + 2**EXP_W - 1 must not exceed DATA_W - 1, so the magnitude never reaches
// the sign bit and no saturation is needed.
module fp_to_linear_seq #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              S,
  input  logic [EXP_W-1:0]  E,
  input  logic [MANT_W-1:0] F,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] D,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

  localparam logic [DATA_W-1:0] ACC_ONE = DATA_W'(1);
  localparam logic [EXP_W-1:0]  CNT_ONE = EXP_W'(1);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [EXP_W-1:0]  cnt;
  logic              sgn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      D         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // inputs are captured here only; later changes on S/E/F are irrelevant
          if (in_valid) begin
            acc   <= {{(DATA_W-MANT_W){1'b0}}, F};
            cnt   <= E;
            sgn   <= S;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // F=0 still walks the full shift so latency depends on E only
          if (cnt == '0) begin
            state <= SIGN;
          end else begin
            acc <= acc << 1;
            cnt <= cnt - CNT_ONE;
          end
        end
        SIGN: begin
          // negating a zero magnitude gives 0, so S=1,F=0 needs no special case
          D         <= sgn ? (~acc + ACC_ONE) : acc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fp_to_linear_seq.sv
// Directed bench for fp_to_linear_seq: vector table, backpressure, mid-shift reset,
// exhaustive sweep against a behavioural model, and an encoder round-trip.
module tb_fp_to_linear_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, S, out_valid, out_ready, busy;
  logic [2:0]  E;
  logic [3:0]  F;
  logic [11:0] D;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_to_linear_seq #(.DATA_W(12), .EXP_W(3), .MANT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .busy(busy)
  );

  typedef struct {
    bit          s;
    bit [2:0]    e;
    bit [3:0]    f;
    logic [11:0] d;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [11:0] model(input bit s, input bit [2:0] e, input bit [3:0] f);
    int m;
    m = int'(f) << e;
    if (s) m = -m;
    return m[11:0];
  endfunction

  // Simple FPCVT-style encoder: smallest exponent such that |d| >> e fits the mantissa.
  task automatic encode(input int d, output bit s, output bit [2:0] e, output bit [3:0] f);
    int mag;
    s = (d < 0);
    mag = s ? -d : d;
    e = 3'd0;
    while ((mag >> e) > 15 && e != 3'd7) e = e + 3'd1;
    f = 4'(mag >> e);
  endtask

  // Called #1 after a rising edge with the decoder in IDLE. Returns once out_valid
  // is seen (lat = edges since accept); a missing result counts as a failed check.
  task automatic launch(input bit s, input bit [2:0] e, input bit [3:0] f,
                        output logic [11:0] d, output int lat);
    S = s; E = e; F = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    S = ~s; E = ~e; F = ~f;  // must not disturb the captured operands
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
    d = D;
  endtask

  // launch + hand-off with out_ready held high
  task automatic convert(input bit s, input bit [2:0] e, input bit [3:0] f,
                         output logic [11:0] d, output int lat);
    launch(s, e, f, d, lat);
    @(posedge clk); #1;
  endtask

  vec_t        vecs[8];
  logic [11:0] d;
  int          lat;
  bit          rs;
  bit [2:0]    re;
  bit [3:0]    rf;

  initial begin
    vecs[0] = '{1'b0, 3'd0, 4'd0,  12'd0};
    vecs[1] = '{1'b0, 3'd3, 4'd12, 12'd96};
    vecs[2] = '{1'b0, 3'd7, 4'd15, 12'd1920};
    vecs[3] = '{1'b1, 3'd7, 4'd15, 12'h880};
    vecs[4] = '{1'b1, 3'd0, 4'd1,  12'hFFF};
    vecs[5] = '{1'b1, 3'd5, 4'd0,  12'd0};
    vecs[6] = '{1'b1, 3'd2, 4'd9,  12'hFDC};
    vecs[7] = '{1'b0, 3'd1, 4'd5,  12'd10};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; S = 1'b0; E = '0; F = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // table: value and latency E+2
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].s, vecs[i].e, vecs[i].f, d, lat);
      chk($sformatf("vec%0d_D", i), 32'(d), 32'(vecs[i].d));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].e) + 32'd2);
      chk($sformatf("vec%0d_pulse", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
    end

    // backpressure: result held, stray in_valid ignored and not queued
    out_ready = 1'b0;
    launch(1'b0, 3'd2, 4'd3, d, lat);
    chk("bp_D", 32'(d), 32'd12);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin S = 1'b1; E = 3'd4; F = 4'd7; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_D%0d", i), 32'(D), 32'd12);
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_D", 32'(D), 32'd12);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_not_queued_busy", 32'(busy), 32'd0);
    chk("bp_not_queued_valid", 32'(out_valid), 32'd0);

    // reset in the middle of SHIFT
    S = 1'b0; E = 3'd6; F = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_D", 32'(D), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    convert(1'b0, 3'd1, 4'd5, d, lat);
    chk("post_rst_D", 32'(d), 32'd10);

    // exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      convert(i[7], i[6:4], i[3:0], d, lat);
      chk($sformatf("sweep_%0d_D", i), 32'(d), 32'(model(i[7], i[6:4], i[3:0])));
    end

    // round-trip: 100 encodes to E=3,F=12 and decodes to 96
    encode(100, rs, re, rf);
    convert(rs, re, rf, d, lat);
    chk("roundtrip_100", 32'(d), 32'd96);
    chk("roundtrip_bound", 32'((100 - int'(d)) < (1 << re)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
